// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 fetch-side blocks.
//
// Contents:
//   - redirect_mode encodings driven by the control/branch unit
//   - pc_unit FSM state encoding (exposed on pc_unit.state)
//   - default reset and trap vectors for the 1 KiB instruction memory
package riscv_pkg;

  // Redirect kinds carried on redirect_mode.
  localparam logic [1:0] REDIR_BRANCH = 2'b00;
  localparam logic [1:0] REDIR_JAL    = 2'b01;
  localparam logic [1:0] REDIR_JALR   = 2'b10;
  localparam logic [1:0] REDIR_TRAP   = 2'b11;

  // Fetch FSM. BOOT exists only to give one bubble after reset release.
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  // Default vectors. Both must stay 4-byte aligned.
  localparam int unsigned DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam int unsigned DEFAULT_TRAP_VEC  = 32'h0000_03F0;

endpackage : riscv_pkg

// File: rtl/pc_target_calc.sv
// Redirect target calculator.
//
// Purely combinational. Sign-extends (or truncates) the immediate to the
// address width, adds it to either the current PC (BRANCH/JAL) or rs1
// (JALR), clears bit 0 for JALR, and flags a target that is not 4-byte
// aligned. All arithmetic wraps modulo 2^ADDR_W with no overflow flag.
//
// Ports:
//   pc          in   ADDR_W  current fetch address (BRANCH/JAL base)
//   mode        in   2       redirect kind (riscv_pkg REDIR_*)
//   offset      in   IMM_W   signed immediate
//   base        in   ADDR_W  rs1 value for JALR
//   target      out  ADDR_W  computed redirect target
//   misaligned  out  1       target[1:0] != 0 (after JALR bit-0 clear)
module pc_target_calc
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int IMM_W  = 20
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        mode,
  input  logic [IMM_W-1:0]  offset,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] target,
  output logic              misaligned
);

  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] add_base;
  logic [ADDR_W-1:0] sum;
  logic              is_jalr;

  // Fit the immediate to the address width. A wider immediate is simply
  // truncated: modulo-2^ADDR_W addition gives the same result either way.
  if (IMM_W >= ADDR_W) begin : g_trunc
    assign off_ext = offset[ADDR_W-1:0];
    if (IMM_W > ADDR_W) begin : g_hi
      // High immediate bits cannot affect a modulo-2^ADDR_W sum.
      logic unused_offset_hi;
      assign unused_offset_hi = ^offset[IMM_W-1:ADDR_W];
    end
  end else begin : g_sext
    assign off_ext = {{(ADDR_W-IMM_W){offset[IMM_W-1]}}, offset};
  end

  assign is_jalr  = (mode == REDIR_JALR);
  assign add_base = is_jalr ? base : pc;
  assign sum      = add_base + off_ext;

  // JALR drops bit 0 before the alignment check, so an odd rs1+imm can
  // still land on a legal target; bit 1 set remains a misalignment.
  always_comb begin
    target = sum;
    if (is_jalr) begin
      target[0] = 1'b0;
    end
  end

  assign misaligned = (target[1:0] != 2'b00);

endmodule : pc_target_calc

// File: rtl/pc_unit.sv
// Program counter for the RV32 fetch stage.
//
// Holds the fetch address, steps it by 4 when instruction memory accepts
// the current request, and applies branch/JAL/JALR/trap redirects. A
// misaligned redirect target is converted into a jump to TRAP_VEC with a
// one-cycle misalign pulse and the offending address captured. A small
// BOOT/RUN/HALTED FSM gates pc_valid and implements halt/resume.
//
// Fetch handshake: pc_out is a request whenever pc_valid=1; it is
// consumed on a rising edge where pc_valid=1, fetch_ready=1 and stall=0,
// and only then does the PC advance to pc_out+4. With pc_valid=1 the PC
// is held stable until consumed, except that a redirect flushes it
// (replaces it) regardless of fetch_ready/stall.
//
// Ports:
//   clk             in   1       clock, rising edge
//   reset           in   1       asynchronous active-low reset
//   fetch_ready     in   1       instruction memory accepts pc_out
//   stall           in   1       hold PC (hazard)
//   redirect_valid  in   1       redirect request present
//   redirect_mode   in   2       00 BRANCH, 01 JAL, 10 JALR, 11 TRAP
//   offset          in   IMM_W   signed immediate
//   base            in   ADDR_W  rs1 value for JALR
//   halt            in   1       request halt
//   resume          in   1       leave halt
//   pc_out          out  ADDR_W  current fetch address
//   pc_plus4        out  ADDR_W  pc_out+4 (link value), combinational
//   pc_valid        out  1       pc_out is a valid fetch request
//   misalign        out  1       one-cycle pulse: redirect target misaligned
//   misalign_addr   out  ADDR_W  last misaligned target
//   state           out  2       FSM state (debug visibility)
module pc_unit
  import riscv_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          IMM_W     = 20,
  parameter int unsigned RESET_VEC = DEFAULT_RESET_VEC,
  parameter int unsigned TRAP_VEC  = DEFAULT_TRAP_VEC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_ready,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_mode,
  input  logic [IMM_W-1:0]  offset,
  input  logic [ADDR_W-1:0] base,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pc_valid,
  output logic              misalign,
  output logic [ADDR_W-1:0] misalign_addr,
  output pc_state_e         state
);

  localparam logic [ADDR_W-1:0] RESET_PC = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] TRAP_PC  = TRAP_VEC[ADDR_W-1:0];

  logic [ADDR_W-1:0] pc_q;
  pc_state_e         state_q;
  logic              misalign_q;
  logic [ADDR_W-1:0] misalign_addr_q;

  logic [ADDR_W-1:0] target;
  logic              target_misaligned;
  logic              is_trap;
  logic              is_flow_redirect;
  logic              advance;

  pc_target_calc #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_target_calc (
    .pc         (pc_q),
    .mode       (redirect_mode),
    .offset     (offset),
    .base       (base),
    .target     (target),
    .misaligned (target_misaligned)
  );

  assign is_trap          = redirect_valid && (redirect_mode == REDIR_TRAP);
  assign is_flow_redirect = redirect_valid && (redirect_mode != REDIR_TRAP);
  assign advance          = fetch_ready && !stall;

  // Single FSM + PC register. Priority in RUN: trap > halt > flow
  // redirect > hold (stall / not ready) > sequential step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q            <= RESET_PC;
      state_q         <= BOOT;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q <= RUN;
        end

        RUN: begin
          if (is_trap) begin
            pc_q <= TRAP_PC;
          end else if (halt) begin
            state_q <= HALTED;
          end else if (is_flow_redirect) begin
            if (target_misaligned) begin
              pc_q            <= TRAP_PC;
              misalign_q      <= 1'b1;
              misalign_addr_q <= target;
            end else begin
              pc_q <= target;
            end
          end else if (advance) begin
            pc_q <= pc_plus4;
          end
        end

        HALTED: begin
          // Only a trap or a clean resume leaves HALTED; halt wins a tie.
          if (is_trap) begin
            pc_q    <= TRAP_PC;
            state_q <= RUN;
          end else if (resume && !halt) begin
            state_q <= RUN;
          end
        end

        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign pc_out        = pc_q;
  assign pc_plus4      = pc_q + ADDR_W'(4);
  assign pc_valid      = (state_q == RUN);
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;
  assign state         = state_q;

endmodule : pc_unit
